pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on lock_in (minimum 2).
REQ-002 SHALL have parameter FILTER_CYCLES, default 1024, the cycles lock must stay high before hold starts (minimum 2).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, the cycles reset stays asserted after filtering (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the PLL output clock domain; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port lock_in, input, 1 bit: PLL lock, asynchronous to clk.
REQ-007 SHALL have port clr_stats, input, 1 bit: synchronous pulse that clears the loss statistics.
REQ-008 SHALL have port sys_reset_n, output, 1 bit: registered active-low reset for the downstream core.
REQ-009 SHALL have port locked_ok, output, 1 bit: high only in state RUN.
REQ-010 SHALL have port lock_loss_cnt, output, 8 bits: saturating count of lock losses.
REQ-011 SHALL have port lost_sticky, output, 1 bit: set on any lock loss, held until cleared.
REQ-012 SHALL have port state_o, output, 3 bits: encoded FSM state for debug.

Function
REQ-013 SHALL synchronize lock_in through SYNC_STAGES flops to give lock_s; no other logic may use lock_in directly.
REQ-014 SHALL implement FSM states WAIT, FILTER, HOLD, RUN, LOST with one shared down-counter.
REQ-015 WAIT: on lock_s=1, go to FILTER and load the counter with FILTER_CYCLES-1.
REQ-016 FILTER: on lock_s=0, go to WAIT (glitch; no loss counted); on counter=0, go to HOLD and load HOLD_CYCLES-1; otherwise decrement.
REQ-017 HOLD: on lock_s=0, go to WAIT (no loss counted); on counter=0, go to RUN; otherwise decrement.
REQ-018 RUN: on lock_s=0, go to LOST.
REQ-019 LOST: lasts exactly one cycle, then goes to WAIT unconditionally.
REQ-020 sys_reset_n SHALL be 1 exactly when the registered state is RUN; locked_ok equals sys_reset_n.
REQ-021 Latency: with lock_in held high, sys_reset_n SHALL rise exactly SYNC_STAGES+FILTER_CYCLES+HOLD_CYCLES+1 clk edges after the first edge that samples lock_in=1.
REQ-022 Loss deassertion: sys_reset_n SHALL fall SYNC_STAGES+1 edges after the edge that samples lock_in=0 during RUN.
REQ-023 On the RUN->LOST transition, lock_loss_cnt SHALL increment, saturating at 255, and lost_sticky SHALL set.
REQ-024 clr_stats=1 SHALL zero lock_loss_cnt and lost_sticky on the next edge.
REQ-025 If clr_stats and a loss coincide, the result SHALL be lock_loss_cnt=1 and lost_sticky=1.
REQ-026 Losses during FILTER or HOLD SHALL NOT count.
REQ-027 state_o encoding SHALL be WAIT=0, FILTER=1, HOLD=2, RUN=3, LOST=4.

Reset
REQ-028 reset_n=0 SHALL asynchronously force: synchronizer flops=0, state=WAIT, counter=0, sys_reset_n=0, locked_ok=0, lock_loss_cnt=0, lost_sticky=0.
REQ-029 Reset asserted mid-RUN SHALL drop sys_reset_n immediately and SHALL NOT count a loss.
REQ-030 After reset release, the full filter and hold sequence SHALL be rerun even if lock_in is already high.

Structure
REQ-031 State encoding constants and the 8-bit stats width SHALL live in shared package pll_mon_pkg.
REQ-032 The synchronizer SHALL be sub-module sync_ff (parameterized depth, async active-low reset); the rest stays flat.

Verification (bench parameters SYNC_STAGES=2, FILTER_CYCLES=8, HOLD_CYCLES=4)
REQ-033 Lock step: lock_in rises and stays high -> sys_reset_n and locked_ok rise on edge 15 after the first sampling edge; lock_loss_cnt=0.
REQ-034 Glitch: lock_in high 5 cycles, low 1, then high -> state returns to WAIT, no loss counted, sys_reset_n rises 15 edges after the re-rise.
REQ-035 Loss in RUN: drop lock_in -> sys_reset_n falls 3 edges later, lock_loss_cnt=1, lost_sticky=1, state passes LOST then WAIT.
REQ-036 Saturation and clear: 300 RUN losses -> lock_loss_cnt=255; clr_stats pulse -> 0/0; clr_stats on the same edge as a loss -> 1/1.
REQ-037 Async reset mid-RUN: reset_n pulsed low between edges -> sys_reset_n=0 with no clk edge, stats=0, full 15-edge sequence repeats.

Source files
------------

// File: rtl/pll_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_mon_pkg
// Description : Shared types for the PLL lock monitor. Holds the FSM state
//               encoding (also exported on the debug port), the width of the
//               loss statistics, and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_mon_pkg;

    localparam int c_STATS_W = 8;

    typedef logic [c_STATS_W-1:0] stats_t;

    // These values appear on state_o, so they are fixed rather than
    // left to the tool.
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_FILTER = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_LOST   = 3'd4
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic stats_t sat_inc(input stats_t v);
        return (v == '1) ? v : v + stats_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_monitor_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-flop synchronizer for a single asynchronous bit.
//               All flops clear to 0 on asynchronous active-low reset.
// Ports       : i_clk   - destination clock
//               i_rst_n - asynchronous active-low reset
//               i_d     - asynchronous input bit
//               o_q     - synchronized output (DEPTH edges of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_monitor
// Description : Watches an asynchronous PLL lock flag and sequences a clean
//               active-low reset for the downstream core. Lock must stay
//               high for FILTER_CYCLES, then reset is held HOLD_CYCLES more
//               before release. Losing lock while running drops the reset,
//               counts the loss (saturating) and sets a sticky flag.
// Ports       : clk           - PLL output clock, rising edge
//               reset_n       - asynchronous active-low reset
//               lock_in       - PLL lock, asynchronous to clk
//               clr_stats     - synchronous clear of the loss statistics
//               sys_reset_n   - registered active-low reset for the core
//               locked_ok     - same as sys_reset_n
//               lock_loss_cnt - saturating count of lock losses while running
//               lost_sticky   - set on any loss while running, until cleared
//               state_o       - FSM state for debug
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lock_in,
    input  logic                 clr_stats,
    output logic                 sys_reset_n,
    output logic                 locked_ok,
    output logic [c_STATS_W-1:0] lock_loss_cnt,
    output logic                 lost_sticky,
    output logic [2:0]           state_o
);

    // One counter serves both FILTER and HOLD, so size it for the larger load.
    localparam int CNT_W = $clog2((FILTER_CYCLES > HOLD_CYCLES) ? FILTER_CYCLES : HOLD_CYCLES);

    localparam logic [CNT_W-1:0] c_FILTER_LOAD = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    logic       w_lock_s;
    logic       w_loss;
    state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic       r_sys_reset_n;
    stats_t     r_loss_cnt;
    logic       r_lost_sticky;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (lock_in),
        .o_q     (w_lock_s)
    );

    // Only a drop seen while running counts as a loss; drops during
    // FILTER/HOLD are treated as the lock not having settled yet.
    assign w_loss = (r_state == ST_RUN) && !w_lock_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_WAIT;
            r_cnt         <= '0;
            r_sys_reset_n <= 1'b0;
            r_loss_cnt    <= '0;
            r_lost_sticky <= 1'b0;
        end else begin
            // Registered from the registered state: the core reset follows
            // the FSM by one edge and is glitch-free.
            r_sys_reset_n <= (r_state == ST_RUN);

            case (r_state)
                ST_WAIT: begin
                    if (w_lock_s) begin
                        r_state <= ST_FILTER;
                        r_cnt   <= c_FILTER_LOAD;
                    end
                end
                ST_FILTER: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= c_HOLD_LOAD;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= ST_WAIT;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        r_state <= ST_LOST;
                    end
                end
                ST_LOST: begin
                    r_state <= ST_WAIT;
                end
                default: begin
                    r_state <= ST_WAIT;
                end
            endcase

            // A loss on the same edge as a clear wins over the clear, so
            // the loss is never silently dropped.
            if (w_loss) begin
                r_loss_cnt    <= clr_stats ? stats_t'(1) : sat_inc(r_loss_cnt);
                r_lost_sticky <= 1'b1;
            end else if (clr_stats) begin
                r_loss_cnt    <= '0;
                r_lost_sticky <= 1'b0;
            end
        end
    end

    assign sys_reset_n   = r_sys_reset_n;
    assign locked_ok     = r_sys_reset_n;
    assign lock_loss_cnt = r_loss_cnt;
    assign lost_sticky   = r_lost_sticky;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_monitor
// Description : Self-checking bench for pll_lock_monitor. A driver applies
//               directed and random lock/clear patterns and, after every
//               clock edge, pushes the outputs predicted by a run-length
//               reference model into a queue. A monitor pops and compares on
//               each falling edge. Directed latency and statistics checks
//               use constants taken straight from the required behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_monitor;

    localparam int S = 2;
    localparam int F = 8;
    localparam int H = 4;
    localparam int RISE_LAT = S + F + H + 1;   // 15

    logic       clk;
    logic       reset_n;
    logic       lock_in;
    logic       clr_stats;
    logic       sys_reset_n;
    logic       locked_ok;
    logic [7:0] lock_loss_cnt;
    logic       lost_sticky;
    logic [2:0] state_o;

    pll_lock_monitor #(
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lock_in       (lock_in),
        .clr_stats     (clr_stats),
        .sys_reset_n   (sys_reset_n),
        .locked_ok     (locked_ok),
        .lock_loss_cnt (lock_loss_cnt),
        .lost_sticky   (lost_sticky),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int       cyc;
        bit       sys;
        int       state;
        int       cnt;
        bit       sticky;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    // The FSM sees lock_in S edges late (delay queue). It releases the core
    // once it has seen F+H+1 consecutive highs; a drop while released is a
    // loss, followed by one dead edge before qualification restarts.
    bit          dq[$];
    int          run_len;
    bit          in_run;
    bit          dead;
    int          m_cnt;
    bit          m_sticky;

    function automatic void model_reset();
        dq.delete();
        for (int i = 0; i < S; i++) dq.push_back(1'b0);
        run_len  = 0;
        in_run   = 0;
        dead     = 0;
        m_cnt    = 0;
        m_sticky = 0;
    endfunction

    function automatic void model_edge(input bit lk, input bit clr);
        exp_t e;
        bit   d;
        bit   loss;
        e.cyc = cyc;
        e.sys = in_run;
        d = dq.pop_front();
        dq.push_back(lk);
        loss = 0;
        if (dead) begin
            dead    = 0;
            run_len = 0;
        end else if (in_run) begin
            if (!d) begin
                in_run = 0;
                dead   = 1;
                loss   = 1;
            end
        end else if (d) begin
            run_len++;
            if (run_len == F + H + 1) in_run = 1;
        end else begin
            run_len = 0;
        end
        if (loss) begin
            m_cnt    = clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
            m_sticky = 1;
        end else if (clr) begin
            m_cnt    = 0;
            m_sticky = 0;
        end
        if (dead)              e.state = 4;
        else if (in_run)       e.state = 3;
        else if (run_len == 0) e.state = 0;
        else if (run_len <= F) e.state = 1;
        else                   e.state = 2;
        e.cnt    = m_cnt;
        e.sticky = m_sticky;
        exp_q.push_back(e);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("sys_reset_n@%0d", e.cyc), int'(sys_reset_n), int'(e.sys));
                check($sformatf("locked_ok@%0d", e.cyc), int'(locked_ok), int'(e.sys));
                check($sformatf("state_o@%0d", e.cyc), int'(state_o), e.state);
                check($sformatf("lock_loss_cnt@%0d", e.cyc), int'(lock_loss_cnt), e.cnt);
                check($sformatf("lost_sticky@%0d", e.cyc), int'(lost_sticky), int'(e.sticky));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Applies inputs for the next edge, waits for it, records the prediction.
    task automatic step(input bit lk, input bit clr);
        lock_in   = lk;
        clr_stats = clr;
        @(posedge clk);
        model_edge(lk, clr);
        cyc++;
        #1;
    endtask

    // First step is the first edge sampling lock_in=1 (edge 0).
    task automatic measure_rise(input string name);
        int idx;
        idx = 0;
        step(1'b1, 1'b0);
        while (!sys_reset_n && idx < 40) begin
            step(1'b1, 1'b0);
            idx++;
        end
        check(name, idx, RISE_LAT);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
        check({tag, "_locked_ok"}, int'(locked_ok), 0);
        check({tag, "_state"}, int'(state_o), 0);
        check({tag, "_loss_cnt"}, int'(lock_loss_cnt), 0);
        check({tag, "_sticky"}, int'(lost_sticky), 0);
    endtask

    // Reset pulse placed between edges; outputs must clear with no clk edge.
    task automatic async_reset_pulse();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        exp_q.delete();
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int hi_len;
        int lo_len;
        reset_n   = 1'b0;
        lock_in   = 1'b0;
        clr_stats = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        #1;
        reset_n = 1'b1;

        // Lock step: clean rise, no loss.
        measure_rise("lock_step_latency");
        repeat (5) step(1'b1, 1'b0);
        check("lock_step_loss_cnt", int'(lock_loss_cnt), 0);

        // Loss in RUN.
        repeat (6) step(1'b0, 1'b0);
        check("loss_cnt_after_loss", int'(lock_loss_cnt), 1);
        check("sticky_after_loss", int'(lost_sticky), 1);

        // Glitch during FILTER: no loss, full latency after re-rise.
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        measure_rise("glitch_relock_latency");
        check("glitch_loss_cnt", int'(lock_loss_cnt), 1);
        repeat (4) step(1'b0, 1'b0);

        // Saturation: 300 losses while running.
        for (int i = 0; i < 300; i++) begin
            repeat (15) step(1'b1, 1'b0);
            repeat (4) step(1'b0, 1'b0);
        end
        check("sat_loss_cnt", int'(lock_loss_cnt), 255);
        check("sat_sticky", int'(lost_sticky), 1);

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("clr_loss_cnt", int'(lock_loss_cnt), 0);
        check("clr_sticky", int'(lost_sticky), 0);

        // Clear on the very edge that sees the loss.
        repeat (15) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("clr_coincide_cnt", int'(lock_loss_cnt), 1);
        check("clr_coincide_sticky", int'(lost_sticky), 1);

        // Random lock behaviour with sporadic clears.
        for (int i = 0; i < 150; i++) begin
            hi_len = int'($urandom_range(1, 24));
            lo_len = int'($urandom_range(1, 6));
            repeat (hi_len) step(1'b1, ($urandom_range(0, 31) == 0));
            repeat (lo_len) step(1'b0, ($urandom_range(0, 31) == 0));
        end

        // Async reset in RUN: immediate drop, stats cleared, full sequence again.
        repeat (16) step(1'b1, 1'b0);
        check("pre_reset_running", int'(sys_reset_n), 1);
        async_reset_pulse();
        measure_rise("post_reset_latency");
        repeat (3) step(1'b1, 1'b0);
        check("post_reset_loss_cnt", int'(lock_loss_cnt), 0);

        step(1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
